sd_resp_crc_rx: RTL and testbench
=================================

# sd_resp_crc_rx

Bit-serial receiver and CRC7 checker for 48-bit SD-bus responses on the CMD line. It is the receive-side counterpart of the command CRC7 generator. It hunts for the start bit, shifts in the frame, and computes CRC7 (x^7+x^3+1) over the first 40 bits while they arrive. When the frame ends it reports the index, the argument, the CRC verdict and the framing status to the SD controller FSM.

## Interface
Parameters:
- `NCR_MAX`, 64: bit-times allowed between arm and start bit before timeout.
- `FRAME_BITS`, 48: total frame length. Fixed at 48; exists only for documentation and assertions.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: arm the receiver. 1-cycle pulse, honoured only in IDLE.
- `bit_en` in 1: sample strobe from the SD clock divider. One pulse per SD bit-time.
- `cmd_in` in 1: CMD line, already synchronised. Sampled only when `bit_en`=1.
- `busy` out 1: high from accepted `start` until the `done` cycle, inclusive.
- `done` out 1: 1-cycle completion pulse.
- `crc_ok` out 1: received CRC7 equals computed CRC7. Valid with `done`, held until the next accepted `start`.
- `frame_err` out 1: end bit was 0. Same validity as `crc_ok`.
- `timeout` out 1: no start bit within `NCR_MAX` bit-times. Same validity as `crc_ok`.
- `tx_bit` out 1: received transmission bit.
- `cmd_idx` out 6: received index field.
- `arg` out 32: received argument or card-status field.
- `crc_rx` out 7: received CRC field.
- `crc_calc` out 7: computed CRC.

## Operation
- Reset value of every output is 0. The FSM resets to IDLE.
- **IDLE**: when `start`=1, clear the CRC register, the shift register, the bit counter and all status outputs. Load the NCR counter with 0. Go to HUNT.
- **HUNT**: on each `bit_en`:
  - If `cmd_in`=0, the start bit is seen. Feed it into the CRC, set bit count to 1, go to BODY.
  - Otherwise increment the NCR counter. If the counter reaches `NCR_MAX`, set `timeout`=1 and go to FIN.
- **BODY**: on each `bit_en`, shift `cmd_in` into the 40-bit shift register and into the CRC. After bit 40 (count=40), go to CRCF.
- CRC update per bit `b`: `fb = crc[6]^b`; `crc <= {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00)`.
- **CRCF**: shift 7 bits MSB-first into `crc_rx`. The CRC register is frozen. After the 7th bit, go to ENDB.
- **ENDB**: on `bit_en`, set `frame_err = ~cmd_in`. Set `crc_ok = (crc_rx == crc_calc)`. Go to FIN.
- **FIN**: assert `done` for one cycle. Deassert `busy` at the end of this cycle. Go to IDLE.
- Field mapping, frame bits 47..0 = start, tx, idx[5:0], arg[31:0], crc[6:0], end:
  - `tx_bit` = shift[38].
  - `cmd_idx` = shift[37:32].
  - `arg` = shift[31:0].
- `crc_calc` continuously reflects the CRC register.
- On timeout, `crc_ok`=0 and `frame_err`=0. The data fields stay 0.
- `start` outside IDLE is ignored.
- `bit_en` outside HUNT, BODY, CRCF and ENDB is ignored.

## Timing
- `cmd_in` is sampled on the `clk` rising edge where `bit_en`=1. No other edge samples it.
- `busy` rises the cycle after `start`.
- `done` rises exactly 1 cycle after the clock edge that samples the end bit (or hits the timeout), then falls the following cycle.
- Frame latency: 48 `bit_en` strobes after the start bit, plus 1 clk. Minimum total from `start` to `done` is 48 strobes + 2 clk.
- Back-to-back: `start` is accepted in the first IDLE cycle after `done`.
- `rst` asserted mid-frame forces IDLE and zeroes all outputs immediately. No `done` is produced.
- `bit_en` on consecutive clk cycles must work: every state advances on a single strobe.
- NCR boundary: exactly `NCR_MAX` high samples produce a timeout. A start bit on sample `NCR_MAX` is still accepted if it comes before the counter reaches `NCR_MAX`, i.e. the check happens on high samples only.

## Structure
- A shared SD package holds:
  - the CRC7 polynomial constant 7'h09;
  - the frame-length constants 48/40/7;
  - the FSM state encoding;
  - a `crc7_next(crc, bit)` function, also usable by the command CRC7 generator.
- One natural sub-module, `crc7_serial`, containing the CRC register with clear/enable/bit inputs. The FSM and shift register stay in the top module.

## Test plan
- Frame 0x40_0000_0000_95 (CMD0 form), LSB end bit 1, `bit_en` every 4 clk, 10 idle high bits first -> `done`=1, `crc_ok`=1, `crc_calc`=0x4A, `cmd_idx`=0, `arg`=0, `tx_bit`=1, `frame_err`=0.
- Frame 0x48_0000_01AA_87 (CMD8 form) -> `crc_ok`=1, `crc_calc`=0x43, `cmd_idx`=8, `arg`=0x000001AA.
- Same CMD8 frame with arg bit 0 flipped (0x1AB) -> `done`=1, `crc_ok`=0, `crc_rx`=0x43, `crc_calc`≠0x43.
- CMD0 frame with end bit 0 -> `crc_ok`=1, `frame_err`=1.
- Line held high, `NCR_MAX`=64 -> `done` and `timeout`=1 one clk after the 64th strobe. With a start bit after 63 highs -> no timeout, normal frame.
- `rst` pulse at bit 20 of a frame, then a new `start` with CMD0 frame, `bit_en` every clk -> no `done` from the first frame; second frame gives `crc_ok`=1.

Source files
------------

// File: rtl/sd_resp_crc_rx_pkg.sv
// Shared SD-bus constants, receiver state encoding and the serial CRC7 step.
package sd_resp_crc_rx_pkg;

    // CRC7 generator x^7 + x^3 + 1, without the implicit x^7 term
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Response frame layout: 40 CRC-covered bits, 7 CRC bits, 1 end bit
    localparam int unsigned FRAME_LEN = 48;
    localparam int unsigned BODY_LEN  = 40;
    localparam int unsigned CRC_LEN   = 7;

    typedef enum logic [2:0] {
        StIdle,
        StHunt,
        StBody,
        StCrcf,
        StEndb,
        StFin
    } rx_state_e;

    // One serial CRC7 step; the command-side generator uses the same step.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_resp_crc_rx_if.sv
// Controller-side bundle of the response receiver: strobes in, frame fields out.
interface sd_resp_crc_rx_if;

    logic        start;
    logic        bit_en;
    logic        cmd_in;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic        frame_err;
    logic        timeout;
    logic        tx_bit;
    logic [5:0]  cmd_idx;
    logic [31:0] arg;
    logic [6:0]  crc_rx;
    logic [6:0]  crc_calc;

    // SD controller side
    modport master (
        output start, bit_en, cmd_in,
        input  busy, done, crc_ok, frame_err, timeout,
        input  tx_bit, cmd_idx, arg, crc_rx, crc_calc
    );

    // Receiver side
    modport slave (
        input  start, bit_en, cmd_in,
        output busy, done, crc_ok, frame_err, timeout,
        output tx_bit, cmd_idx, arg, crc_rx, crc_calc
    );

endinterface

// File: rtl/sd_resp_crc_rx_crc7.sv
// Serial CRC7 register with synchronous clear and per-bit enable.
module crc7_serial
    import sd_resp_crc_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q;

    // Clear has priority; otherwise advance one bit per enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= 7'h00;
        end else if (clr) begin
            crc_q <= 7'h00;
        end else if (en) begin
            crc_q <= crc7_next(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_resp_crc_rx.sv
// SD CMD-line response receiver: start-bit hunt, 48-bit frame capture, CRC7 check.
module sd_resp_crc_rx
    import sd_resp_crc_rx_pkg::*;
#(
    parameter int unsigned NCR_MAX    = 64,
    parameter int unsigned FRAME_BITS = FRAME_LEN
) (
    input logic            clk,
    input logic            rst,
    sd_resp_crc_rx_if.slave bus
);

    localparam int unsigned NcrW     = $clog2(NCR_MAX + 1);
    localparam int unsigned BodyBits = FRAME_BITS - CRC_LEN - 1;

    rx_state_e state_q, state_d;

    logic                start, bit_en, cmd_in;
    logic [BODY_LEN-1:0] shift_q;
    logic [5:0]          cnt_q;
    logic [NcrW-1:0]     ncr_q;
    logic [6:0]          crc_rx_q;
    logic [6:0]          crc_calc;
    logic                crc_ok_q, frame_err_q, timeout_q;
    logic                crc_clr, crc_en;
    logic                ncr_last, body_last, crc_last;

    assign start  = bus.start;
    assign bit_en = bus.bit_en;
    assign cmd_in = bus.cmd_in;

    // Next high sample in HUNT would bring the counter to NCR_MAX
    assign ncr_last  = (ncr_q == NcrW'(NCR_MAX - 1));
    assign body_last = (cnt_q == 6'(BodyBits - 1));
    assign crc_last  = (cnt_q == 6'(CRC_LEN - 1));

    // The start bit and the body bits feed the CRC; the CRC field itself does not.
    assign crc_clr = (state_q == StIdle) && start;
    assign crc_en  = bit_en && (((state_q == StHunt) && !cmd_in) || (state_q == StBody));

    crc7_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (cmd_in),
        .crc    (crc_calc)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every state advances on a single strobe
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StHunt;
            StHunt: begin
                if (bit_en) begin
                    if (!cmd_in)       state_d = StBody;
                    else if (ncr_last) state_d = StFin;
                end
            end
            StBody: if (bit_en && body_last) state_d = StCrcf;
            StCrcf: if (bit_en && crc_last) state_d = StEndb;
            StEndb: if (bit_en) state_d = StEndb == StEndb ? StFin : StEndb;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Frame datapath: shift register, counters, CRC field and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            ncr_q       <= '0;
            crc_rx_q    <= '0;
            crc_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        shift_q     <= '0;
                        cnt_q       <= '0;
                        ncr_q       <= '0;
                        crc_rx_q    <= '0;
                        crc_ok_q    <= 1'b0;
                        frame_err_q <= 1'b0;
                        timeout_q   <= 1'b0;
                    end
                end
                StHunt: begin
                    if (bit_en) begin
                        if (!cmd_in) begin
                            // Start bit lands in shift[0] and ends up at the MSB
                            shift_q <= {shift_q[BODY_LEN-2:0], cmd_in};
                            cnt_q   <= 6'd1;
                        end else begin
                            ncr_q <= ncr_q + 1'b1;
                            if (ncr_last) timeout_q <= 1'b1;
                        end
                    end
                end
                StBody: begin
                    if (bit_en) begin
                        shift_q <= {shift_q[BODY_LEN-2:0], cmd_in};
                        cnt_q   <= body_last ? 6'd0 : cnt_q + 6'd1;
                    end
                end
                StCrcf: begin
                    if (bit_en) begin
                        crc_rx_q <= {crc_rx_q[5:0], cmd_in};
                        cnt_q    <= cnt_q + 6'd1;
                    end
                end
                StEndb: begin
                    if (bit_en) begin
                        frame_err_q <= ~cmd_in;
                        crc_ok_q    <= (crc_rx_q == crc_calc);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and field outputs
    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.done      = (state_q == StFin);
        bus.crc_ok    = crc_ok_q;
        bus.frame_err = frame_err_q;
        bus.timeout   = timeout_q;
        bus.tx_bit    = shift_q[38];
        bus.cmd_idx   = shift_q[37:32];
        bus.arg       = shift_q[31:0];
        bus.crc_rx    = crc_rx_q;
        bus.crc_calc  = crc_calc;
    end

    // A completed (non-timeout) frame always carries a 0 start bit at the MSB
    start_bit_at_msb: assert property (@(posedge clk) disable iff (rst)
        (state_q == StFin && !timeout_q) |-> !shift_q[BODY_LEN-1]);

endmodule

// File: tb/tb_sd_resp_crc_rx.sv
// Directed bench for the SD response receiver with hand-computed expectations.
module tb_sd_resp_crc_rx;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sd_resp_crc_rx_if bus ();

    sd_resp_crc_rx #(
        .NCR_MAX    (64),
        .FRAME_BITS (48)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit for 'gap' clocks; bit_en is high in the last of them.
    task automatic send_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            bus.cmd_in = b;
            bus.bit_en = (i == gap - 1);
        end
    endtask

    task automatic send_highs(input int n, input int gap);
        for (int i = 0; i < n; i++) send_bit(1'b1, gap);
    endtask

    task automatic send_frame(input logic [47:0] f, input int gap);
        for (int i = 47; i >= 0; i--) send_bit(f[i], gap);
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        bus.bit_en = 1'b0;
        bus.cmd_in = 1'b1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy after start"}, 40'(bus.busy), 40'd1);
    endtask

    // Called right after the final strobe was presented.
    task automatic expect_done(input string tag);
        @(negedge clk);
        bus.bit_en = 1'b0;
        check({tag, " done"}, 40'(bus.done), 40'd1);
        check({tag, " busy with done"}, 40'(bus.busy), 40'd1);
    endtask

    task automatic expect_idle(input string tag, input logic ok_hold);
        @(negedge clk);
        check({tag, " done falls"}, 40'(bus.done), 40'd0);
        check({tag, " busy falls"}, 40'(bus.busy), 40'd0);
        check({tag, " crc_ok held"}, 40'(bus.crc_ok), 40'(ok_hold));
    endtask

    logic seen_done;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bit_en = 1'b0;
        bus.cmd_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset busy", 40'(bus.busy), 40'd0);
        check("reset done", 40'(bus.done), 40'd0);
        check("reset crc_ok", 40'(bus.crc_ok), 40'd0);
        check("reset arg", 40'(bus.arg), 40'd0);
        check("reset crc_calc", 40'(bus.crc_calc), 40'd0);

        // CMD0 response form, strobe every 4 clk, 10 idle highs first
        do_start("cmd0");
        send_highs(10, 4);
        send_frame(48'h40_0000_0000_95, 4);
        expect_done("cmd0");
        check("cmd0 crc_ok", 40'(bus.crc_ok), 40'd1);
        check("cmd0 crc_calc", 40'(bus.crc_calc), 40'h4A);
        check("cmd0 crc_rx", 40'(bus.crc_rx), 40'h4A);
        check("cmd0 cmd_idx", 40'(bus.cmd_idx), 40'd0);
        check("cmd0 arg", 40'(bus.arg), 40'd0);
        check("cmd0 tx_bit", 40'(bus.tx_bit), 40'd1);
        check("cmd0 frame_err", 40'(bus.frame_err), 40'd0);
        check("cmd0 timeout", 40'(bus.timeout), 40'd0);
        expect_idle("cmd0", 1'b1);

        // CMD8 response form, back-to-back start
        do_start("cmd8");
        send_highs(3, 2);
        send_frame(48'h48_0000_01AA_87, 2);
        expect_done("cmd8");
        check("cmd8 crc_ok", 40'(bus.crc_ok), 40'd1);
        check("cmd8 crc_calc", 40'(bus.crc_calc), 40'h43);
        check("cmd8 cmd_idx", 40'(bus.cmd_idx), 40'd8);
        check("cmd8 arg", 40'(bus.arg), 40'h0000_01AA);
        expect_idle("cmd8", 1'b1);

        // Last message bit flipped: CRC differs by x^7 mod g = 0x09
        do_start("cmd8bad");
        send_frame(48'h48_0000_01AB_87, 3);
        expect_done("cmd8bad");
        check("cmd8bad crc_ok", 40'(bus.crc_ok), 40'd0);
        check("cmd8bad crc_rx", 40'(bus.crc_rx), 40'h43);
        check("cmd8bad crc_calc", 40'(bus.crc_calc), 40'h4A);
        expect_idle("cmd8bad", 1'b0);

        // CMD0 with end bit 0
        do_start("endbit");
        send_frame(48'h40_0000_0000_94, 4);
        expect_done("endbit");
        check("endbit crc_ok", 40'(bus.crc_ok), 40'd1);
        check("endbit frame_err", 40'(bus.frame_err), 40'd1);
        expect_idle("endbit", 1'b1);

        // Line held high: timeout on the 64th high sample
        do_start("tmo");
        send_highs(63, 2);
        @(negedge clk);
        bus.bit_en = 1'b0;
        check("tmo no done at 63", 40'(bus.done), 40'd0);
        send_bit(1'b1, 1);
        expect_done("tmo");
        check("tmo timeout", 40'(bus.timeout), 40'd1);
        check("tmo crc_ok", 40'(bus.crc_ok), 40'd0);
        check("tmo frame_err", 40'(bus.frame_err), 40'd0);
        check("tmo arg", 40'(bus.arg), 40'd0);
        check("tmo tx_bit", 40'(bus.tx_bit), 40'd0);
        expect_idle("tmo", 1'b0);

        // Start bit as sample 64 after 63 highs is still accepted
        do_start("ncr63");
        send_highs(63, 1);
        send_frame(48'h48_0000_01AA_87, 1);
        expect_done("ncr63");
        check("ncr63 timeout", 40'(bus.timeout), 40'd0);
        check("ncr63 crc_ok", 40'(bus.crc_ok), 40'd1);
        check("ncr63 arg", 40'(bus.arg), 40'h0000_01AA);
        expect_idle("ncr63", 1'b1);

        // Reset at bit 20 of a frame, strobe every clk
        do_start("rst");
        for (int i = 47; i > 27; i--) begin
            logic [47:0] f;
            f = 48'h48_0000_01AA_87;
            send_bit(f[i], 1);
        end
        @(negedge clk);
        bus.bit_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst busy", 40'(bus.busy), 40'd0);
        check("rst cmd_idx", 40'(bus.cmd_idx), 40'd0);
        check("rst crc_calc", 40'(bus.crc_calc), 40'd0);
        seen_done = bus.done;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen_done = seen_done | bus.done;
        end
        check("rst no done", 40'(seen_done), 40'd0);

        do_start("after_rst");
        send_frame(48'h40_0000_0000_95, 1);
        expect_done("after_rst");
        check("after_rst crc_ok", 40'(bus.crc_ok), 40'd1);
        check("after_rst crc_calc", 40'(bus.crc_calc), 40'h4A);
        check("after_rst frame_err", 40'(bus.frame_err), 40'd0);
        expect_idle("after_rst", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
